// File: rtl/game_pkg.sv
// Shared types and constants for the breakout per-frame update scheduler.
package game_pkg;
    localparam int V_BLANK_START_DEF = 516;
    localparam int TIMEOUT_DEF       = 255;
    localparam int SPEED_W           = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PADDLE  = 3'd1,
        BALL    = 3'd2,
        COLLIDE = 3'd3,
        BLOCK   = 3'd4,
        DONE    = 3'd5
    } sched_state_t;

    // Request vector {paddle, ball, collide, block} that is asserted in a given state.
    function automatic logic [3:0] req_vec(input sched_state_t st);
        logic [3:0] v;
        case (st)
            PADDLE:  v = 4'b1000;
            BALL:    v = 4'b0100;
            COLLIDE: v = 4'b0010;
            BLOCK:   v = 4'b0001;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/vblank_edge_det.sv
// Registered vCount == V_BLANK_START compare with rising-edge detect.
// Produces one single-cycle frame_start pulse per frame.
module vblank_edge_det
    import game_pkg::*;
#(
    parameter int V_BLANK_START = V_BLANK_START_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] vCount,
    output logic       frame_start
);
    logic cmp_d;
    logic cmp_q;
    logic cmp_dly_q;
    logic start_d;
    logic start_q;

    // Next-state compare and edge terms.
    always_comb begin
        cmp_d   = (vCount == 10'(V_BLANK_START));
        start_d = cmp_q & ~cmp_dly_q;
    end

    // Compare, delay and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_q     <= 1'b0;
            cmp_dly_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            cmp_dly_q <= cmp_q;
            start_q   <= start_d;
        end
    end

    assign frame_start = start_q;
endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame breakout datapath sequencer: paddle, then speed x (ball, collide, block) sub-steps.
// Optional per-stage ack watchdog and sticky timeout output under FRAME_SCHED_WATCHDOG_EN.
module frame_update_scheduler
    import game_pkg::*;
#(
    parameter int V_BLANK_START = V_BLANK_START_DEF
`ifdef FRAME_SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         vCount,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    output logic               paddle_req,
    input  logic               paddle_ack,
    output logic               ball_req,
    input  logic               ball_ack,
    output logic               collide_req,
    input  logic               collide_ack,
    output logic               block_req,
    input  logic               block_ack,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic [SPEED_W-1:0] substep
`ifdef FRAME_SCHED_WATCHDOG_EN
    ,
    output logic               timeout
`endif
);
    sched_state_t       state_d, state_q;
    logic [SPEED_W-1:0] spd_d, spd_q;
    logic [SPEED_W-1:0] substep_d, substep_q;
    logic [3:0]         req_d, req_q;
    logic               busy_d, busy_q;
    logic               frame_done_d, frame_done_q;
    logic               overrun_d, overrun_q;
    logic               frame_start;
    logic               stage_ack;
    logic               advance;

    vblank_edge_det #(
        .V_BLANK_START(V_BLANK_START)
    ) u_edge (
        .clk        (clk),
        .rst        (rst),
        .vCount     (vCount),
        .frame_start(frame_start)
    );

    // Select the ack belonging to the current stage; acks in other states are ignored.
    always_comb begin
        case (state_q)
            PADDLE:  stage_ack = paddle_ack;
            BALL:    stage_ack = ball_ack;
            COLLIDE: stage_ack = collide_ack;
            BLOCK:   stage_ack = block_ack;
            default: stage_ack = 1'b0;
        endcase
    end

`ifdef FRAME_SCHED_WATCHDOG_EN
    logic [7:0] wd_cnt_d, wd_cnt_q;
    logic       timeout_d, timeout_q;
    logic       wd_expire;

    // Watchdog: a stalled stage is abandoned as if acked after TIMEOUT_CYCLES cycles.
    always_comb begin
        wd_expire = (req_vec(state_q) != 4'b0000) && (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
        advance   = stage_ack | wd_expire;
        timeout_d = timeout_q | (wd_expire & ~stage_ack);
        if (advance || (req_vec(state_q) == 4'b0000)) begin
            wd_cnt_d = 8'd0;
        end else begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // Without the watchdog a stage waits indefinitely for its ack.
    always_comb begin
        advance = stage_ack;
    end
`endif

    // Sequencer next state; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d   = state_q;
        spd_d     = spd_q;
        substep_d = substep_q;
        overrun_d = overrun_q | (frame_start && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (frame_start && enable) begin
                    state_d   = PADDLE;
                    spd_d     = speed;
                    substep_d = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            PADDLE: begin
                if (advance) begin
                    state_d = (spd_q != 2'd0) ? BALL : DONE;
                end else begin
                    state_d = PADDLE;
                end
            end
            BALL: begin
                if (advance) begin
                    state_d = COLLIDE;
                end else begin
                    state_d = BALL;
                end
            end
            COLLIDE: begin
                if (advance) begin
                    state_d = BLOCK;
                end else begin
                    state_d = COLLIDE;
                end
            end
            BLOCK: begin
                if (advance && (substep_q == spd_q - 2'd1)) begin
                    state_d = DONE;
                end else if (advance) begin
                    state_d   = BALL;
                    substep_d = substep_q + 2'd1;
                end else begin
                    state_d = BLOCK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d        = req_vec(state_d);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            spd_q        <= 2'd0;
            substep_q    <= 2'd0;
            req_q        <= 4'b0000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            spd_q        <= spd_d;
            substep_q    <= substep_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign {paddle_req, ball_req, collide_req, block_req} = req_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign substep    = substep_q;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: table vectors, randomized frames, corner sequences.
module tb_frame_update_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] vCount = 10'd0;
    logic       enable = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       paddle_ack = 1'b0, ball_ack = 1'b0, collide_ack = 1'b0, block_ack = 1'b0;
    logic       paddle_req, ball_req, collide_req, block_req;
    logic       busy, frame_done, overrun;
    logic [1:0] substep;
`ifdef FRAME_SCHED_WATCHDOG_EN
    logic       timeout;
`endif

    int checks = 0;
    int failures = 0;

    logic [3:0] prev_req = 4'd0;
    logic [3:0] cur_req = 4'd0;
    logic [3:0] ack_block = 4'd0;
    int  fixed_dly = 0;
    bit  rand_dly = 1'b0;
    int  cur_dly = 0;
    int  wait_cnt = 0;
    byte stage_ch [4] = '{8'd80, 8'd66, 8'd67, 8'd75};
    byte obs_q[$];
    int  sub_q[$];
    int  done_cnt = 0, busy_cycles = 0, onehot_bad = 0, busy_bad = 0, blk_high = 0;

    typedef struct {
        bit en;
        int spd;
        int dly;
        int nreq;
        int busy_cyc;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    frame_update_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .vCount     (vCount),
        .enable     (enable),
        .speed      (speed),
        .paddle_req (paddle_req),
        .paddle_ack (paddle_ack),
        .ball_req   (ball_req),
        .ball_ack   (ball_ack),
        .collide_req(collide_req),
        .collide_ack(collide_ack),
        .block_req  (block_req),
        .block_ack  (block_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .substep    (substep)
`ifdef FRAME_SCHED_WATCHDOG_EN
        ,
        .timeout    (timeout)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, log transactions, then drive acks.
    task automatic step();
        @(posedge clk);
        #1;
        cur_req = {paddle_req, ball_req, collide_req, block_req};
        if ($countones(cur_req) > 1) onehot_bad++;
        if (busy != ((cur_req != 4'd0) || frame_done)) busy_bad++;
        if (busy) busy_cycles++;
        if (frame_done) done_cnt++;
        if (block_req) blk_high++;
        for (int i = 0; i < 4; i++) begin
            if (cur_req[3-i] && !prev_req[3-i]) begin
                obs_q.push_back(stage_ch[i]);
                if (i == 1) sub_q.push_back(int'(substep));
                wait_cnt = 0;
                cur_dly = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
            end
        end
        prev_req    = cur_req;
        paddle_ack  = cur_req[3] && !ack_block[3] && (wait_cnt >= cur_dly);
        ball_ack    = cur_req[2] && !ack_block[2] && (wait_cnt >= cur_dly);
        collide_ack = cur_req[1] && !ack_block[1] && (wait_cnt >= cur_dly);
        block_ack   = cur_req[0] && !ack_block[0] && (wait_cnt >= cur_dly);
        if (cur_req != 4'd0) wait_cnt++;
    endtask

    task automatic clear_log();
        obs_q.delete();
        sub_q.delete();
        done_cnt = 0; busy_cycles = 0; onehot_bad = 0; busy_bad = 0; blk_high = 0;
    endtask

    task automatic do_start();
        vCount = 10'd515; step();
        vCount = 10'd516; step(); step(); step();
        vCount = 10'd517; step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_finished"}, int'(busy), 0);
    endtask

    // Reference: a frame is paddle once, then speed repetitions of ball/collide/block.
    task automatic compare_model(input string tag, input bit en, input int spd);
        byte exp_q[$];
        int  exp_sub[$];
        if (en) begin
            exp_q.push_back(stage_ch[0]);
            for (int s = 0; s < spd; s++) begin
                exp_q.push_back(stage_ch[1]);
                exp_q.push_back(stage_ch[2]);
                exp_q.push_back(stage_ch[3]);
                exp_sub.push_back(s);
            end
        end
        check({tag, "_nreq"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_order"}, int'(obs_q[i]), int'(exp_q[i]));
        check({tag, "_nsub"}, sub_q.size(), exp_sub.size());
        for (int i = 0; i < exp_sub.size() && i < sub_q.size(); i++)
            check({tag, "_substep"}, sub_q[i], exp_sub[i]);
        check({tag, "_done"}, done_cnt, en ? 1 : 0);
        check({tag, "_onehot"}, onehot_bad, 0);
        check({tag, "_busy_rule"}, busy_bad, 0);
    endtask

    task automatic run_frame(input string tag, input bit en, input int spd, input bit scramble);
        clear_log();
        enable = en;
        speed  = 2'(spd);
        do_start();
        if (scramble) begin
            speed  = 2'($urandom);
            enable = 1'($urandom);
        end
        wait_idle(tag, 300);
        compare_model(tag, en, spd);
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 0, 0, 1, 2};
        tbl[1] = '{1'b1, 3, 0, 10, 11};
        tbl[2] = '{1'b1, 3, 2, 10, 31};
        tbl[3] = '{1'b1, 1, 1, 4, 9};
        tbl[4] = '{1'b1, 2, 0, 7, 8};
        tbl[5] = '{1'b0, 2, 0, 0, 0};
        tbl[6] = '{1'b1, 2, 3, 7, 29};
        tbl[7] = '{1'b1, 1, 2, 4, 13};

        // Reset state
        rst = 1'b0;
        step(); step();
        check("rst_reqs", int'(cur_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_substep", int'(substep), 0);
        rst = 1'b1;
        step();

        // Frame-start latency
        clear_log();
        enable = 1'b1; speed = 2'd0; fixed_dly = 0;
        vCount = 10'd515; step();
        vCount = 10'd516; step();
        check("lat_edgeN", int'(paddle_req), 0);
        step();
        check("lat_edgeN1", int'(paddle_req), 0);
        step();
        check("lat_edgeN2", int'(paddle_req), 1);
        vCount = 10'd517;
        wait_idle("lat", 50);
        compare_model("lat", 1'b1, 0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            fixed_dly = tbl[i].dly;
            rand_dly  = 1'b0;
            run_frame("tbl", tbl[i].en, tbl[i].spd, 1'b0);
            check("tbl_nreq", obs_q.size(), tbl[i].nreq);
            check("tbl_busy_cycles", busy_cycles, tbl[i].busy_cyc);
        end

        // Speed latched at frame start
        clear_log();
        fixed_dly = 1; enable = 1'b1; speed = 2'd1;
        do_start();
        n = 0;
        while (!ball_req && n < 50) begin step(); n++; end
        check("latch_ball_seen", int'(ball_req), 1);
        speed = 2'd3;
        wait_idle("latch1", 100);
        compare_model("latch1", 1'b1, 1);
        clear_log();
        do_start();
        wait_idle("latch2", 100);
        compare_model("latch2", 1'b1, 3);

        // Randomized frames with random ack latency and mid-frame input changes
        rand_dly = 1'b1;
        for (int f = 0; f < 24; f++) begin
            run_frame("rnd", $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)), 1'b1);
        end
        check("rnd_overrun", int'(overrun), 0);

        // Overrun: second frame start while paddle stage is stalled
        clear_log();
        rand_dly = 1'b0; fixed_dly = 0; ack_block = 4'b1000;
        enable = 1'b1; speed = 2'd2;
        do_start();
        check("ovr_pre", int'(overrun), 0);
        do_start();
        step(); step(); step();
        check("ovr_set", int'(overrun), 1);
        check("ovr_busy", int'(busy), 1);
        check("ovr_single_p", obs_q.size(), 1);
        ack_block = 4'b0000;
        wait_idle("ovr", 100);
        compare_model("ovr", 1'b1, 2);
        check("ovr_sticky", int'(overrun), 1);

        // Asynchronous reset during COLLIDE
        clear_log();
        ack_block = 4'b0010; speed = 2'd1; enable = 1'b1;
        do_start();
        n = 0;
        while (!collide_req && n < 50) begin step(); n++; end
        check("arst_collide_seen", int'(collide_req), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_collide_low", int'(collide_req), 0);
        check("arst_busy_low", int'(busy), 0);
        check("arst_overrun_clr", int'(overrun), 0);
        rst = 1'b1;
        ack_block = 4'b0000;
        clear_log();
        for (int i = 0; i < 6; i++) step();
        check("arst_idle_busy", busy_cycles, 0);
        check("arst_idle_nreq", obs_q.size(), 0);

`ifdef FRAME_SCHED_WATCHDOG_EN
        // Watchdog abandons a block stage whose ack never comes
        clear_log();
        ack_block = 4'b0001; speed = 2'd1; fixed_dly = 0;
        check("wd_timeout_pre", int'(timeout), 0);
        do_start();
        wait_idle("wd", 400);
        check("wd_block_cycles", blk_high, 255);
        check("wd_timeout", int'(timeout), 1);
        check("wd_done", done_cnt, 1);
        ack_block = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
